eth_mii_rx_filter: RTL
======================

// Module: eth_mii_rx_filter
// PURPOSE
//  MII receive-side frame filter/extractor. Runs on eth_rx_clk (25 MHz, 4-bit nibbles).
//  Assembles bytes, finds the SFD, and matches the destination MAC against MY_MAC or broadcast.
//  On an accepted frame, captures PAYLOAD_BYTES bytes starting at payload offset PAYLOAD_OFFSET.
//  Publishes them atomically at end of frame and keeps ok/drop frame counters for LED/debug logic.
// PARAMETERS
//  MY_MAC          48'h123456789abc  unicast destination address accepted
//  ACCEPT_BCAST    0                 1: also accept ff:ff:ff:ff:ff:ff
//  PAYLOAD_OFFSET  0                 first captured byte, counted from the first byte after EtherType (byte 14)
//  PAYLOAD_BYTES   1                 bytes captured (1..8)
//  CNT_W           16                width of frame counters
// PORTS
//  eth_rx_clk    in   1                       MII receive clock; sole clock
//  resetn        in   1                       synchronous, active-low reset
//  eth_rx_dv     in   1                       MII data valid
//  eth_rxd       in   4                       MII nibble; low nibble of each byte first
//  eth_rxerr     in   1                       MII receive error
//  out_data      out  8*PAYLOAD_BYTES         last accepted payload; byte 0 in [7:0]
//  out_valid     out  1                       1-cycle pulse when out_data updates
//  frames_ok     out  CNT_W                   accepted-frame count, wraps
//  frames_drop   out  CNT_W                   dropped-frame count (SFD seen, not accepted), wraps
// BEHAVIOUR
//  Reset: out_data=0, out_valid=0, both counters=0, state=SYNC, nibble phase=0.
//  Byte = {eth_rxd, prev_nibble}. It is valid on the odd nibble (phase 1). Phase clears whenever dv=0.
//  FSM:
//   SYNC   - wait for dv=0, then go to IDLE. This avoids locking onto a frame already in progress at reset release.
//   IDLE   - dv=1 -> PREAM.
//   PREAM  - on valid byte 8'hd5 -> HDR with byte index=0. dv=0 -> IDLE (no count).
//   HDR    - bytes 0..5 compare against the destination address.
//            On the first mismatch (not bcast-allowed) -> DROP.
//            Bytes 14+PAYLOAD_OFFSET .. +PAYLOAD_BYTES-1 go into a shadow register, never directly to out_data.
//            Byte index saturates at 2047.
//   DROP   - ignore input until dv=0; frames_drop+=1 on the cycle dv falls; -> IDLE.
//  End of frame (dv 1->0 in HDR):
//   accept only if all of the following hold:
//    - the address matched;
//    - all payload bytes were captured;
//    - the nibble phase is even (no dribble nibble);
//    - eth_rxerr was never high during the frame.
//   On accept, on the cycle after dv falls: out_data<=shadow, out_valid=1 for 1 cycle, frames_ok+=1.
//   On reject: frames_drop+=1; out_data is held unchanged.
//   Latency: 1 eth_rx_clk after dv deasserts.
//  eth_rxerr=1 in PREAM or HDR: the frame is marked bad and completes via DROP.
//  A new frame (dv rising) in the cycle right after commit is legal: IDLE->PREAM proceeds in parallel with the commit.
//  Counters wrap modulo 2^CNT_W. ok and drop never increment in the same cycle.
//  Reset asserted mid-frame: outputs return to reset values, FSM goes to SYNC, the partial frame is discarded and not counted.
// CONFIGURATION
//  ETH_RX_FCS_CHECK_EN defined:
//   - CRC-32 (poly 04C11DB7, reflected, init ffffffff) runs over every byte after the SFD, FCS included.
//   - Accept additionally requires the final residue == 32'hc704dd7b; otherwise the frame is dropped and counted.
//  Undefined: no CRC logic; the last 4 bytes are treated as data and not checked.
// STRUCTURE
//  Shared package eth_pkg: SFD=8'hd5, BCAST_MAC, CRC32_POLY, CRC32_RESIDUE, FSM state enum, MAX_IDX=2047.
//  One sub-module, eth_crc32_byte (combinational next-CRC from {crc, byte}).
//   Instantiated only under ETH_RX_FCS_CHECK_EN; the surrounding CRC register lives in this block.
// TESTING
//  1 Frame to 12:34:56:78:9a:bc, payload byte0=0x5a, valid FCS
//    -> out_data=0x5a, out_valid 1 cycle exactly 1 clk after dv falls, frames_ok=1.
//  2 Same frame to 12:34:56:78:9a:bd -> out_data unchanged, frames_drop=1, no out_valid.
//  3 Broadcast frame: ACCEPT_BCAST=0 -> dropped; ACCEPT_BCAST=1 -> accepted.
//  4 eth_rxerr pulsed on byte 20, or a 15th payload-truncated frame (dv drops at byte 13) -> frames_drop+=1, out_data held.
//  5 Reset released while dv=1 mid-frame -> nothing captured or counted until dv=0. The next good frame is accepted.
//  6 With ETH_RX_FCS_CHECK_EN: one FCS bit flipped -> drop. Without the macro, the same frame is accepted.
//    PAYLOAD_BYTES=4, PAYLOAD_OFFSET=2 -> out_data = payload bytes 2..5, byte 2 in [7:0].

Source files
------------

// File: rtl/eth_pkg.sv
// eth_pkg: shared constants, FSM state type and helpers for the MII receive path
package eth_pkg;
    localparam logic [7:0]  SFD           = 8'hd5;
    localparam logic [47:0] BCAST_MAC     = 48'hffffffffffff;
    localparam logic [31:0] CRC32_POLY    = 32'h04c11db7;
    localparam logic [31:0] CRC32_RESIDUE = 32'hc704dd7b;
    localparam int          MAX_IDX       = 2047;
    typedef enum logic [2:0] {SYNC, IDLE, PREAM, HDR, DROP} rx_state_t;
    function automatic logic [31:0] rev32(input logic [31:0] v);
        for (int i = 0; i < 32; i++) rev32[i] = v[31-i];
    endfunction
endpackage

// File: rtl/eth_crc32_byte.sv
// eth_crc32_byte: combinational reflected CRC-32 update by one byte
//   crc      in  32  current CRC register
//   data     in  8   byte, LSB processed first
//   crc_next out 32  CRC after the byte
module eth_crc32_byte
    import eth_pkg::*;
(
    input  logic [31:0] crc,
    input  logic [7:0]  data,
    output logic [31:0] crc_next
);
    localparam logic [31:0] POLY_R = rev32(CRC32_POLY);
    logic [31:0] c;
    always_comb begin
        c = crc ^ {24'h0, data};
        for (int i = 0; i < 8; i++) c = c[0] ? (c >> 1) ^ POLY_R : c >> 1;
        crc_next = c;
    end
endmodule

// File: rtl/eth_mii_rx_filter.sv
// eth_mii_rx_filter: MII receive filter; matches destination MAC and extracts a payload slice
//   eth_rx_clk  in   MII receive clock
//   resetn      in   synchronous active-low reset
//   eth_rx_dv   in   MII data valid
//   eth_rxd     in   MII nibble, low nibble of each byte first
//   eth_rxerr   in   MII receive error
//   out_data    out  last accepted payload slice, byte 0 in [7:0]
//   out_valid   out  one-cycle pulse when out_data updates
//   frames_ok   out  accepted-frame counter (wraps)
//   frames_drop out  dropped-frame counter (wraps)
// Define ETH_RX_FCS_CHECK_EN to also require a correct FCS on accept.
module eth_mii_rx_filter
    import eth_pkg::*;
#(
    parameter logic [47:0] MY_MAC         = 48'h123456789abc,
    parameter bit          ACCEPT_BCAST   = 1'b0,
    parameter int          PAYLOAD_OFFSET = 0,
    parameter int          PAYLOAD_BYTES  = 1,
    parameter int          CNT_W          = 16
) (
    input  logic                       eth_rx_clk,
    input  logic                       resetn,
    input  logic                       eth_rx_dv,
    input  logic [3:0]                 eth_rxd,
    input  logic                       eth_rxerr,
    output logic [8*PAYLOAD_BYTES-1:0] out_data,
    output logic                       out_valid,
    output logic [CNT_W-1:0]           frames_ok,
    output logic [CNT_W-1:0]           frames_drop
);
    localparam logic [10:0] FIRST_I = 11'(14 + PAYLOAD_OFFSET);
    localparam logic [10:0] NEED_I  = 11'(14 + PAYLOAD_OFFSET + PAYLOAD_BYTES);
    localparam logic [10:0] MAX_I   = 11'(MAX_IDX);
    rx_state_t                  state;
    logic                       phase;
    logic [3:0]                 prev;
    logic [10:0]                idx;
    logic                       uni_m, bc_m, uni_n, bc_n;
    logic [8*PAYLOAD_BYTES-1:0] shadow;
    logic [7:0]                 rx_byte, mac_byte, bc_byte;
    logic                       byte_v, crc_ok, accept;
    assign rx_byte = {eth_rxd, prev};
    assign byte_v  = eth_rx_dv && phase;
    always_comb begin
        mac_byte = '0;
        bc_byte  = '0;
        for (int k = 0; k < 6; k++)
            if (idx == 11'(k)) begin
                mac_byte = MY_MAC[8*(5-k) +: 8];
                bc_byte  = BCAST_MAC[8*(5-k) +: 8];
            end
        uni_n = uni_m && rx_byte == mac_byte;
        bc_n  = ACCEPT_BCAST && bc_m && rx_byte == bc_byte;
    end
`ifdef ETH_RX_FCS_CHECK_EN
    logic [31:0] crc, crc_next;
    eth_crc32_byte u_crc (.crc(crc), .data(rx_byte), .crc_next(crc_next));
    // Held at the init value outside HDR so it is fresh on the first byte after the SFD
    always_ff @(posedge eth_rx_clk)
        if (!resetn || state != HDR) crc <= '1;
        else if (byte_v) crc <= crc_next;
    // The register is LSB-first; the residue constant is in MSB-first form
    assign crc_ok = rev32(crc) == CRC32_RESIDUE;
`else
    assign crc_ok = 1'b1;
`endif
    // Still in HDR at dv fall implies the address matched and no rxerr was seen
    assign accept = idx >= NEED_I && !phase && crc_ok;
    always_ff @(posedge eth_rx_clk) begin
        if (!resetn) begin
            state       <= SYNC;
            phase       <= 1'b0;
            prev        <= '0;
            idx         <= '0;
            uni_m       <= 1'b0;
            bc_m        <= 1'b0;
            shadow      <= '0;
            out_data    <= '0;
            out_valid   <= 1'b0;
            frames_ok   <= '0;
            frames_drop <= '0;
        end else begin
            phase     <= eth_rx_dv && !phase;
            prev      <= eth_rxd;
            out_valid <= 1'b0;
            case (state)
                SYNC:  if (!eth_rx_dv) state <= IDLE;
                IDLE:  if (eth_rx_dv) state <= PREAM;
                PREAM: if (!eth_rx_dv) state <= IDLE;
                       else if (eth_rxerr) state <= DROP;
                       else if (byte_v && rx_byte == SFD) begin
                           state <= HDR;
                           idx   <= '0;
                           uni_m <= 1'b1;
                           bc_m  <= 1'b1;
                       end
                HDR:   if (!eth_rx_dv) begin
                           state <= IDLE;
                           if (accept) begin
                               out_data  <= shadow;
                               out_valid <= 1'b1;
                               frames_ok <= frames_ok + 1'b1;
                           end else frames_drop <= frames_drop + 1'b1;
                       end else if (eth_rxerr) state <= DROP;
                       else if (byte_v) begin
                           if (idx < 11'd6) begin
                               uni_m <= uni_n;
                               bc_m  <= bc_n;
                               if (!uni_n && !bc_n) state <= DROP;
                           end
                           for (int k = 0; k < PAYLOAD_BYTES; k++)
                               if (idx == FIRST_I + 11'(k)) shadow[8*k +: 8] <= rx_byte;
                           if (idx != MAX_I) idx <= idx + 1'b1;
                       end
                DROP:  if (!eth_rx_dv) begin
                           state       <= IDLE;
                           frames_drop <= frames_drop + 1'b1;
                       end
                default: state <= SYNC;
            endcase
        end
    end
endmodule
